// File: rtl/uart_pkg.sv
// uart_pkg: register offsets, CON bit indices and TX FSM encoding shared by the UART bus controller
package uart_pkg;
  localparam logic [3:0] REG_TXD = 4'h0;
  localparam logic [3:0] REG_RXD = 4'h4;
  localparam logic [3:0] REG_CON = 4'h8;
  localparam int CON_TX_IE = 0;
  localparam int CON_RX_IE = 1;
  localparam int CON_RX_READY = 2;
  localparam int CON_TX_DONE = 3;
  localparam int CON_TX_FULL = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, LAUNCH = 2'd1, WAIT_DONE = 2'd2} tx_state_t;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: TX byte FIFO; a push while full is taken only together with a pop
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [7:0]                 wdata,
  output logic [7:0]                 rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr_en, rd_en;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/uart_bus_ctrl.sv
// uart_bus_ctrl: CPU register front end for a byte UART with TX FIFO, TX launch FSM and RX buffer
module uart_bus_ctrl
  import uart_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [3:0] BASE_SEL   = 4'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  addr,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  input  logic        tx_status,
  input  logic [7:0]  rx_data,
  input  logic        rx_status
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  tx_state_t state;
  logic [1:0] tx_sync;
  logic [2:0] rx_sync;
  logic [7:0] rx_buf, head;
  logic [4:0] con;
  logic [CW-1:0] count;
  logic tx_ie, rx_ie, rx_ready, tx_done, overrun, full, empty;
  logic sel, txd_wr, con_wr, rxd_rd, pop, tx_busy, rx_edge, done_set, unused;
  assign sel = addr[7:4] == BASE_SEL;
  assign txd_wr = sel & wr & (addr[3:0] == REG_TXD);
  assign con_wr = sel & wr & (addr[3:0] == REG_CON);
  assign rxd_rd = sel & rd & (addr[3:0] == REG_RXD);
  assign tx_busy = tx_sync[1];
  assign rx_edge = rx_sync[1] & ~rx_sync[2];
  assign pop = (state == IDLE) & ~empty;
  assign done_set = (state == WAIT_DONE) & ~tx_busy & (count == '0);
  assign irq = (tx_ie & tx_done) | (rx_ie & rx_ready);
  assign unused = ^wdata[31:8];
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) fifo (
    .clk(clk), .reset(reset), .push(txd_wr), .pop(pop), .wdata(wdata[7:0]),
    .rdata(head), .full(full), .empty(empty), .count(count)
  );
  always_comb begin
    con = '0;
    con[CON_TX_IE] = tx_ie;
    con[CON_RX_IE] = rx_ie;
    con[CON_RX_READY] = rx_ready;
    con[CON_TX_DONE] = tx_done;
    con[CON_TX_FULL] = full;
  end
  assign rdata = !(rd && sel) ? '0 :
                 addr[3:0] == REG_RXD ? {23'b0, overrun, rx_buf} :
                 addr[3:0] == REG_CON ? {27'b0, con} : '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tx_sync <= '0;
      rx_sync <= '0;
    end else begin
      tx_sync <= {tx_sync[0], tx_status};
      rx_sync <= {rx_sync[1:0], rx_status};
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      tx_en <= 1'b0;
      tx_data <= '0;
    end else
      case (state)
        IDLE: if (!empty) begin
          state <= LAUNCH;
          tx_en <= 1'b1;
          tx_data <= head;
        end
        LAUNCH: if (tx_busy) begin
          state <= WAIT_DONE;
          tx_en <= 1'b0;
        end
        WAIT_DONE: if (!tx_busy) state <= IDLE;
        default: state <= IDLE;
      endcase
  // a read that coincides with a new byte keeps rx_ready set and never flags overrun
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tx_ie <= 1'b0;
      rx_ie <= 1'b0;
      tx_done <= 1'b0;
      rx_ready <= 1'b0;
      overrun <= 1'b0;
      rx_buf <= '0;
    end else begin
      if (con_wr) begin
        tx_ie <= wdata[CON_TX_IE];
        rx_ie <= wdata[CON_RX_IE];
      end
      tx_done <= done_set | (tx_done & ~(con_wr & wdata[CON_TX_DONE]));
      if (rx_edge) begin
        rx_buf <= rx_data;
        rx_ready <= 1'b1;
        overrun <= rx_ready & ~rxd_rd;
      end else if (rxd_rd) begin
        rx_ready <= 1'b0;
        overrun <= 1'b0;
      end
    end
endmodule

// File: tb/tb_uart_bus_ctrl.sv
// tb_uart_bus_ctrl: directed bench with an event-level model (byte queue, flag set) checked every cycle
`timescale 1ns/1ps
module tb_uart_bus_ctrl;
  localparam int DEPTH = 4;
  localparam logic [7:0] TXD = 8'h00, RXD = 8'h04, CON = 8'h08;
  logic clk = 0, reset = 1, rd = 0, wr = 0, tx_status = 0, rx_status = 0, irq, tx_en;
  logic [7:0] addr = 0, tx_data, rx_data = 0;
  logic [31:0] wdata = 0, rdata;
  int checks = 0, errors = 0, launches = 0, base = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m_buf = 0, last = 0;
  logic m_tx_ie = 0, m_rx_ie = 0, m_tx_done = 0, m_rx_ready = 0, m_ovr = 0;
  logic settled = 0, stall = 0, hold = 0, prev_en = 0, found = 0;

  uart_bus_ctrl #(.FIFO_DEPTH(DEPTH), .BASE_SEL(4'h0)) dut (
    .clk(clk), .reset(reset), .addr(addr), .rd(rd), .wr(wr), .wdata(wdata),
    .rdata(rdata), .irq(irq), .tx_data(tx_data), .tx_en(tx_en),
    .tx_status(tx_status), .rx_data(rx_data), .rx_status(rx_status)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] m_con();
    return {27'b0, exp_q.size() == DEPTH, m_tx_done, m_rx_ready, m_rx_ie, m_tx_ie};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [31:0] d);
    logic take;
    take = (a == TXD) && (exp_q.size() < DEPTH);
    addr = a; wdata = d; wr = 1;
    @(posedge clk);
    if (take) exp_q.push_back(d[7:0]);
    if (a == CON) begin
      m_tx_ie = d[0];
      m_rx_ie = d[1];
      if (d[3]) m_tx_done = 0;
    end
    #1 wr = 0;
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
    addr = a; rd = 1;
    @(negedge clk) check(name, rdata, exp);
    @(posedge clk);
    if (a == RXD) begin m_rx_ready = 0; m_ovr = 0; end
    #1 rd = 0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    settled = 0; rx_data = b; rx_status = 1;
    idle(6);
    rx_status = 0;
    idle(4);
    if (m_rx_ready) m_ovr = 1;
    m_buf = b; m_rx_ready = 1; settled = 1;
  endtask

  // sender: busy 3 cycles after a request, for 20 cycles, longer while stalled
  initial forever begin
    @(negedge clk);
    if (tx_en) begin
      repeat (3) @(posedge clk);
      #1 tx_status = 1;
      repeat (20) @(posedge clk);
      while (stall) @(posedge clk);
      #1 tx_status = 0;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("rst_tx_en", tx_en, 0);
      check("rst_irq", irq, 0);
      check("rst_tx_data", tx_data, 0);
    end else begin
      if (tx_en && !prev_en) begin
        if (exp_q.size() == 0) check("no_spurious_tx_en", tx_en, 0);
        else begin
          last = exp_q.pop_front();
          check("tx_order", tx_data, last);
          launches++;
          hold = 1;
        end
      end else if (hold && (tx_en || tx_status)) check("tx_hold", tx_data, last);
      if (settled) check("irq", irq, (m_tx_ie & m_tx_done) | (m_rx_ie & m_rx_ready));
    end
    prev_en = tx_en;
  end

  initial begin
    #2 reset = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1;
    idle(3);
    settled = 1;
    rd_chk("con_reset", CON, 32'h0);
    rd_chk("rxd_reset", RXD, 32'h0);
    wr_reg(8'h10, 32'hEE);
    wr_reg(8'h18, 32'h03);
    idle(8);
    rd_chk("con_unsel_wr", CON, 32'h0);
    // single frame
    wr_reg(CON, 32'h01);
    rd_chk("rd_unsel", 8'h18, 32'h0);
    rd_chk("rd_unmapped", 8'h0C, 32'h0);
    rd_chk("rd_txd", TXD, 32'h0);
    settled = 0;
    wr_reg(TXD, 32'h141);
    for (int i = 0; i < 10 && !tx_en; i++) idle(1);
    check("t1_tx_en", tx_en, 1);
    check("t1_tx_data", tx_data, 32'h41);
    for (int i = 0; i < 10 && !tx_status; i++) idle(1);
    check("t1_en_until_busy", tx_en, 1);
    for (int i = 0; i < 10 && tx_en; i++) idle(1);
    check("t1_en_drop", tx_en, 0);
    for (int i = 0; i < 40 && tx_status; i++) idle(1);
    idle(6);
    m_tx_done = 1; settled = 1;
    check("t1_irq", irq, 1);
    rd_chk("t1_con", CON, 32'h09);
    wr_reg(CON, 32'h09);
    rd_chk("t1_clr", CON, m_con());
    // overflow while the sender is stalled on a previous frame
    settled = 0; stall = 1;
    wr_reg(TXD, 32'hA5);
    for (int i = 0; i < 10 && !tx_status; i++) idle(1);
    for (int i = 0; i < 10 && tx_en; i++) idle(1);
    check("t2_wait_done", {tx_en, tx_status}, 2'b01);
    for (int i = 1; i <= 6; i++) wr_reg(TXD, i);
    rd_chk("t2_full", CON, 32'h11);
    base = launches;
    stall = 0;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) idle(1);
    for (int i = 0; i < 40 && !tx_status; i++) idle(1);
    for (int i = 0; i < 40 && tx_status; i++) idle(1);
    idle(6);
    check("t2_sent", launches - base, 4);
    m_tx_done = 1; settled = 1;
    rd_chk("t2_done", CON, 32'h09);
    // receive path
    wr_reg(CON, 32'h0B);
    rx_byte(8'h5A);
    check("t3_irq", irq, 1);
    rd_chk("t3_rxd", RXD, 32'h5A);
    rd_chk("t3_ready_clr", CON, 32'h03);
    rx_byte(8'h11);
    rx_byte(8'h22);
    rd_chk("t4_overrun", RXD, 32'h122);
    rd_chk("t4_ovr_clr", RXD, {23'b0, m_ovr, m_buf});
    rd_chk("t4_con", CON, m_con());
    // tx_done set wins over a same-cycle clear
    settled = 0;
    wr_reg(TXD, 32'h77);
    for (int i = 0; i < 20 && !tx_status; i++) idle(1);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      addr = CON; wdata = 32'h09; wr = 1;
      @(posedge clk);
      #1 found = irq;
    end
    wr = 0;
    check("t5_set_wins", found, 1);
    m_tx_ie = 1; m_rx_ie = 0; m_tx_done = 1; settled = 1;
    rd_chk("t5_con", CON, 32'h09);
    // RXD read coinciding with a new byte
    wr_reg(CON, 32'h0A);
    settled = 0; rx_data = 8'h44; rx_status = 1; found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      addr = RXD; rd = 1;
      @(posedge clk);
      #1 found = irq;
    end
    rd = 0; rx_status = 0;
    check("t6_edge_wins", found, 1);
    m_buf = 8'h44; m_rx_ready = 1; m_ovr = 0; settled = 1;
    idle(2);
    rd_chk("t6_rxd", RXD, 32'h44);
    // reset during WAIT_DONE with two bytes queued
    wr_reg(CON, 32'h01);
    settled = 0; stall = 1;
    wr_reg(TXD, 32'hB1);
    for (int i = 0; i < 10 && !tx_status; i++) idle(1);
    for (int i = 0; i < 10 && tx_en; i++) idle(1);
    wr_reg(TXD, 32'hB2);
    wr_reg(TXD, 32'hB3);
    base = launches;
    reset = 0;
    exp_q.delete();
    hold = 0; m_tx_ie = 0; m_rx_ie = 0; m_tx_done = 0; m_rx_ready = 0; m_ovr = 0; m_buf = 0;
    idle(3);
    check("t7_rst_en", tx_en, 0);
    reset = 1; stall = 0;
    idle(60);
    check("t7_no_retry", launches - base, 0);
    settled = 1;
    rd_chk("t7_con", CON, 32'h0);
    rd_chk("t7_rxd", RXD, 32'h0);
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_bus_ctrl.md
UART_BUS_CTRL -- requirements
Module: uart_bus_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning TX FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter BASE_SEL, default 4'h0, meaning addr[7:4] value that selects this block.
REQ-003 SHALL have port clk, input, 1, meaning the single system clock for all logic.
REQ-004 SHALL have port reset, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port addr, input, 8, meaning CPU byte address; [7:4] selects the block, [3:0] selects the register.
REQ-006 SHALL have ports rd and wr, input, 1 each, meaning CPU read and write strobes, one cycle per access.
REQ-007 SHALL have port wdata, input, 32, meaning CPU write data.
REQ-008 SHALL have port rdata, output, 32, meaning CPU read data.
REQ-009 SHALL have port irq, output, 1, meaning level interrupt to the CPU.
REQ-010 SHALL have ports tx_data (output, 8, byte to sender) and tx_en (output, 1, send request).
REQ-011 SHALL have port tx_status, input, 1, meaning sender busy (1 = shifting a frame).
REQ-012 SHALL have ports rx_data (input, 8, received byte) and rx_status (input, 1, rises once per received byte).

Function
REQ-013 SHALL map registers: 0x0 TXD (write-only), 0x4 RXD (read-only), 0x8 CON (read/write).
REQ-014 SHALL define CON[4:0]: 0 tx_ie (RW), 1 rx_ie (RW), 2 rx_ready (RO), 3 tx_done (write 1 to clear), 4 tx_full (RO).
REQ-015 SHALL drive rdata combinationally in the cycle rd is high; unselected or unmapped reads return 0.
REQ-016 SHALL push wdata[7:0] into the TX FIFO on a TXD write when count < FIFO_DEPTH, and silently drop it when full.
REQ-017 SHALL accept a TXD write when full if the FSM pops in the same cycle, leaving count unchanged.
REQ-018 SHALL pass tx_status and rx_status through 2-flop synchronizers before any use.
REQ-019 SHALL run the TX FSM with states IDLE, LAUNCH, and WAIT_DONE.
REQ-020 SHALL move IDLE to LAUNCH when the FIFO is non-empty, popping the head into tx_data_reg.
REQ-021 SHALL hold tx_en = 1 throughout LAUNCH and move LAUNCH to WAIT_DONE when synced tx_status = 1.
REQ-022 SHALL, in WAIT_DONE, move to IDLE when synced tx_status = 0, setting tx_done if the FIFO is now empty.
REQ-023 SHALL hold tx_data stable from LAUNCH entry until WAIT_DONE exit.
REQ-024 SHALL, on a synced rx_status rising edge, latch rx_data into rx_buf and set rx_ready.
REQ-025 SHALL set an overrun flag if rx_ready was already 1 at that edge, replacing rx_buf with the new byte.
REQ-026 SHALL return {23'b0, overrun, rx_buf} on an RXD read and clear rx_ready and overrun on that edge.
REQ-027 SHALL, when an RXD read and an rx edge coincide, latch the new byte, leave rx_ready = 1, and leave overrun = 0.
REQ-028 SHALL give precedence to set over a same-cycle CON write-1-to-clear of tx_done.
REQ-029 SHALL compute irq combinationally as (tx_ie & tx_done) | (rx_ie & rx_ready).

Reset
REQ-030 SHALL, while reset = 0, clear FIFO pointers and count, force FSM to IDLE, tx_en = 0, tx_data = 0, CON = 0, rx_buf = 0, overrun = 0, synchronizers = 0, and irq = 0.
REQ-031 SHALL drop any in-flight frame request on reset mid-LAUNCH or mid-WAIT_DONE, with no retry after release.

Structure
REQ-032 SHALL place register offsets, CON bit indices, and FSM state encodings in shared package uart_pkg.
REQ-033 SHALL implement the TX FIFO as sub-module uart_tx_fifo (push, pop, full, empty, count).

Verification
REQ-034 SHALL verify: write 0x41 to TXD, sender model busy 3 cycles later for 20 cycles -> tx_en high until busy seen, tx_data = 0x41, tx_done = 1 after busy falls, irq = 1 if tx_ie.
REQ-035 SHALL verify: 6 back-to-back TXD writes 0x01..0x06 with sender stalled -> 0x05 and 0x06 dropped, tx_full = 1, bytes 0x01..0x04 sent in order.
REQ-036 SHALL verify: rx_status edge with rx_data = 0x5A, then RXD read -> rdata = 0x0000005A, rx_ready cleared next cycle.
REQ-037 SHALL verify: two rx edges (0x11 then 0x22) without a read -> RXD reads 0x00000122.
REQ-038 SHALL verify: reset asserted in WAIT_DONE with 2 bytes queued -> tx_en = 0, FIFO empty, no further tx_en after release.
REQ-039 SHALL verify: CON write 0x08 in the same cycle tx_done sets -> tx_done reads 1.
